decode_stage: RTL and testbench

//  Core Decode pipeline stage, directly downstream of Fetch. Accepts {addr, insn} from Fetch over a valid/ready

---
 rtl/core_pkg.sv | 70 +++++++
 rtl/decode_rv32i.sv | 49 ++++
 rtl/decode_stage.sv | 90 +++++++++
 tb/tb_decode_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: uop classes, immediate formats, RV32I opcodes
// and the decoded micro-op bundle passed from Decode to Execute.
package core_pkg;

   typedef enum logic [3:0] {
      UOP_LUI,
      UOP_AUIPC,
      UOP_JAL,
      UOP_JALR,
      UOP_BRANCH,
      UOP_LOAD,
      UOP_STORE,
      UOP_OP_IMM,
      UOP_OP,
      UOP_MISC_MEM,
      UOP_SYSTEM,
      UOP_ILLEGAL
   } uop_class_e;

   typedef enum logic [2:0] {
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_R
   } imm_fmt_e;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef struct packed {
      uop_class_e  cls;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic        funct7b5;
      logic [31:0] imm;
      logic        illegal;
   } decoded_uop_t;

   function automatic logic [31:0] imm_gen(
      input logic [31:0] insn,
      input imm_fmt_e    fmt
   );
      logic [31:0] imm;
      unique case (fmt)
         FMT_I: imm = {{20{insn[31]}}, insn[31:20]};
         FMT_S: imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
         FMT_B: imm = {{19{insn[31]}}, insn[31], insn[7],
                       insn[30:25], insn[11:8], 1'b0};
         FMT_U: imm = {insn[31:12], 12'b0};
         FMT_J: imm = {{11{insn[31]}}, insn[31], insn[19:12],
                       insn[20], insn[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/decode_rv32i.sv
// Combinational RV32I decoder: raw instruction word to decoded_uop_t.
// Unknown opcodes and non-32-bit encodings decode as ILLEGAL with rd=0.
module decode_rv32i
   import core_pkg::*;
(
   input  logic [31:0]  insn,
   output decoded_uop_t uop
);

   logic [6:0] op;
   uop_class_e cls;
   imm_fmt_e   fmt;

   assign op = insn[6:0];

   always_comb begin
      cls = UOP_ILLEGAL;
      fmt = FMT_R;
      unique case (1'b1)
         (op == OPC_LUI):      begin cls = UOP_LUI;      fmt = FMT_U; end
         (op == OPC_AUIPC):    begin cls = UOP_AUIPC;    fmt = FMT_U; end
         (op == OPC_JAL):      begin cls = UOP_JAL;      fmt = FMT_J; end
         (op == OPC_JALR):     begin cls = UOP_JALR;     fmt = FMT_I; end
         (op == OPC_BRANCH):   begin cls = UOP_BRANCH;   fmt = FMT_B; end
         (op == OPC_LOAD):     begin cls = UOP_LOAD;     fmt = FMT_I; end
         (op == OPC_STORE):    begin cls = UOP_STORE;    fmt = FMT_S; end
         (op == OPC_OP_IMM):   begin cls = UOP_OP_IMM;   fmt = FMT_I; end
         (op == OPC_OP):       begin cls = UOP_OP;       fmt = FMT_R; end
         (op == OPC_MISC_MEM): begin cls = UOP_MISC_MEM; fmt = FMT_R; end
         (op == OPC_SYSTEM):   begin cls = UOP_SYSTEM;   fmt = FMT_I; end
         default: ;
      endcase
   end

   // Branch, store and illegal uops never write the register file
   always_comb begin
      uop          = '0;
      uop.cls      = cls;
      uop.illegal  = (cls == UOP_ILLEGAL);
      uop.rs1      = insn[19:15];
      uop.rs2      = insn[24:20];
      uop.funct3   = insn[14:12];
      uop.funct7b5 = insn[30];
      uop.imm      = imm_gen(insn, fmt);
      uop.rd       = (cls == UOP_BRANCH || cls == UOP_STORE ||
                      cls == UOP_ILLEGAL) ? 5'd0 : insn[11:7];
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: registered uop output plus 1-entry skid, flushed on redirect.
// DECODE_PERF_CNT_EN adds perf_decoded/perf_illegal/perf_flushed counters.
module decode_stage
   import core_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  backend_redirect_en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-3:0] in_addr,
   input  logic [31:0]           in_insn,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-3:0] out_addr,
   output decoded_uop_t          out_uop
`ifdef DECODE_PERF_CNT_EN
  ,output logic [31:0]           perf_decoded,
   output logic [31:0]           perf_illegal,
   output logic [31:0]           perf_flushed
`endif
);

   decoded_uop_t          dec_uop;
   logic                  skid_valid;
   logic [ADDR_WIDTH-3:0] skid_addr;
   decoded_uop_t          skid_uop;
   logic                  accept;
   logic                  load;

   decode_rv32i u_dec (
      .insn (in_insn),
      .uop  (dec_uop)
   );

   assign in_ready = !skid_valid;
   assign accept   = in_valid & in_ready;
   assign load     = !out_valid | out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_addr   <= '0;
         out_uop    <= '0;
         skid_valid <= 1'b0;
         skid_addr  <= '0;
         skid_uop   <= '0;
      end else if (backend_redirect_en) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (load) begin
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_addr   <= skid_addr;
            out_uop    <= skid_uop;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= accept;
            if (accept) begin
               out_addr <= in_addr;
               out_uop  <= dec_uop;
            end
         end
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_addr  <= in_addr;
         skid_uop   <= dec_uop;
      end
   end

`ifdef DECODE_PERF_CNT_EN
   // A flush wins over a same-cycle handoff, so that uop counts as flushed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_decoded <= '0;
         perf_illegal <= '0;
         perf_flushed <= '0;
      end else if (backend_redirect_en) begin
         perf_flushed <= perf_flushed + 32'(out_valid) + 32'(skid_valid);
      end else if (out_valid & out_ready) begin
         perf_decoded <= perf_decoded + 32'd1;
         if (out_uop.illegal)
            perf_illegal <= perf_illegal + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus random traffic
// against a queue-based occupancy model and an arithmetic RV32I decoder.
module tb_decode_stage;
   import core_pkg::*;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [AW-3:0] in_addr = '0;
   logic [31:0]   in_insn = '0;
   logic          in_ready;
   logic          out_valid;
   logic [AW-3:0] out_addr;
   decoded_uop_t  out_uop;
`ifdef DECODE_PERF_CNT_EN
   logic [31:0]   perf_decoded;
   logic [31:0]   perf_illegal;
   logic [31:0]   perf_flushed;
`endif

   decode_stage #(.ADDR_WIDTH(AW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .backend_redirect_en (flush),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_addr             (in_addr),
      .in_insn             (in_insn),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_addr            (out_addr),
      .out_uop             (out_uop)
`ifdef DECODE_PERF_CNT_EN
     ,.perf_decoded        (perf_decoded),
      .perf_illegal        (perf_illegal),
      .perf_flushed        (perf_flushed)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-3:0] a;
      logic [31:0]   i;
   } ent_t;

   ent_t        q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   int unsigned m_dec = 0;
   int unsigned m_ill = 0;
   int unsigned m_flu = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic decoded_uop_t ref_decode(input logic [31:0] x);
      decoded_uop_t u;
      int s;
      int imm;
      u = '0;
      u.rd = x[11:7];
      u.rs1 = x[19:15];
      u.rs2 = x[24:20];
      u.funct3 = x[14:12];
      u.funct7b5 = x[30];
      s = $signed(x) >>> 20;
      imm = 0;
      case (x[6:0])
         7'h37: begin u.cls = UOP_LUI;   imm = int'(x & 32'hFFFFF000); end
         7'h17: begin u.cls = UOP_AUIPC; imm = int'(x & 32'hFFFFF000); end
         7'h6F: begin
            u.cls = UOP_JAL;
            imm = (x[31] ? -(1 << 20) : 0) + (int'(x[19:12]) << 12)
                + (int'(x[20]) << 11) + (int'(x[30:21]) << 1);
         end
         7'h67: begin u.cls = UOP_JALR; imm = s; end
         7'h63: begin
            u.cls = UOP_BRANCH;
            u.rd = 0;
            imm = (x[31] ? -4096 : 0) + (int'(x[7]) << 11)
                + (int'(x[30:25]) << 5) + (int'(x[11:8]) << 1);
         end
         7'h03: begin u.cls = UOP_LOAD; imm = s; end
         7'h23: begin
            u.cls = UOP_STORE;
            u.rd = 0;
            imm = (s & ~31) | int'(x[11:7]);
         end
         7'h13: begin u.cls = UOP_OP_IMM; imm = s; end
         7'h33: u.cls = UOP_OP;
         7'h0F: u.cls = UOP_MISC_MEM;
         7'h73: begin u.cls = UOP_SYSTEM; imm = s; end
         default: begin
            u.cls = UOP_ILLEGAL;
            u.illegal = 1'b1;
            u.rd = 0;
         end
      endcase
      u.imm = imm;
      return u;
   endfunction

   task automatic compare_all();
      check("in_ready", in_ready, q.size() < 2);
      check("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
         check("out_addr", out_addr, q[0].a);
         check("out_uop", out_uop, ref_decode(q[0].i));
      end
`ifdef DECODE_PERF_CNT_EN
      check("perf_decoded", perf_decoded, m_dec);
      check("perf_illegal", perf_illegal, m_ill);
      check("perf_flushed", perf_flushed, m_flu);
`endif
   endtask

   // One clock: model updates with the inputs seen at the edge,
   // outputs are checked on the following falling edge.
   task automatic step();
      bit acc;
      ent_t e;
      @(posedge clk);
      acc = in_valid && (q.size() < 2);
      if (flush) begin
         m_flu += q.size();
         q.delete();
      end else begin
         if (q.size() > 0 && out_ready) begin
            e = q.pop_front();
            m_dec++;
            if (ref_decode(e.i).illegal) m_ill++;
         end
         if (acc) q.push_back('{in_addr, in_insn});
      end
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input logic v, input logic [AW-3:0] a,
                        input logic [31:0] i);
      in_valid = v;
      in_addr = a;
      in_insn = i;
   endtask

   function automatic logic [31:0] rand_insn();
      logic [6:0] ops [11];
      logic [31:0] x;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
              7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
      x = $urandom;
      if ($urandom_range(0, 9) < 8)
         x[6:0] = ops[$urandom_range(0, 10)];
      return x;
   endfunction

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      compare_all();
      check("rst_addr", out_addr, 0);
      check("rst_uop", out_uop, 0);

      out_ready = 1'b1;
      drive(1, 30'h1, 32'h00500093);
      step();
      check("addi_cls", out_uop.cls, UOP_OP_IMM);
      check("addi_rd", out_uop.rd, 1);
      check("addi_rs1", out_uop.rs1, 0);
      check("addi_imm", out_uop.imm, 32'h5);
      check("addi_ill", out_uop.illegal, 0);

      drive(1, 30'h2, 32'h12345137);
      step();
      check("lui_cls", out_uop.cls, UOP_LUI);
      check("lui_rd", out_uop.rd, 2);
      check("lui_imm", out_uop.imm, 32'h12345000);
      drive(1, 30'h3, 32'hFE000EE3);
      step();
      check("beq_cls", out_uop.cls, UOP_BRANCH);
      check("beq_imm", out_uop.imm, 32'hFFFFFFFC);
      check("beq_rd", out_uop.rd, 0);

      drive(1, 30'h4, 32'h00000000);
      step();
      check("ill0_cls", out_uop.cls, UOP_ILLEGAL);
      check("ill0_flag", out_uop.illegal, 1);
      drive(1, 30'h5, 32'hFFFFFFFF);
      step();
      check("ill1_cls", out_uop.cls, UOP_ILLEGAL);
      check("ill1_flag", out_uop.illegal, 1);
      drive(0, 0, 0);
      step();
`ifdef DECODE_PERF_CNT_EN
      check("perf_ill2", perf_illegal, 2);
`endif

      out_ready = 1'b0;
      drive(1, 30'hA, 32'h00100113);
      step();
      check("bp_rdy_a", in_ready, 1);
      drive(1, 30'hB, 32'h00200193);
      step();
      check("bp_rdy_b", in_ready, 0);
      drive(1, 30'hC, 32'h00300213);
      step();
      check("bp_hold_a", out_addr, 30'hA);
      out_ready = 1'b1;
      step();
      check("bp_ord_b", out_addr, 30'hB);
      step();
      check("bp_ord_c", out_addr, 30'hC);
      drive(0, 0, 0);
      step();
      check("bp_empty", out_valid, 0);

      out_ready = 1'b0;
      drive(1, 30'hD, 32'h00000013);
      step();
      drive(1, 30'hE, 32'h00000013);
      step();
      check("fl_full", in_ready, 0);
      flush = 1'b1;
      drive(1, 30'hF, 32'h00000013);
      step();
      check("fl_ov", out_valid, 0);
      check("fl_ir", in_ready, 1);
      flush = 1'b0;
      drive(0, 0, 0);
      out_ready = 1'b1;
      repeat (2) begin
         step();
         check("fl_gone", out_valid, 0);
      end
`ifdef DECODE_PERF_CNT_EN
      check("perf_fl2", perf_flushed, 2);
`endif

      out_ready = 1'b0;
      drive(1, 30'h10, 32'h00A00093);
      step();
      drive(0, 0, 0);
      check("rs_pre", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("rs_ov", out_valid, 0);
      check("rs_ir", in_ready, 1);
      check("rs_addr", out_addr, 0);
      check("rs_uop", out_uop, 0);
      q.delete();
      m_dec = 0;
      m_ill = 0;
      m_flu = 0;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      drive(1, 30'h11, 32'h00B00093);
      step();
      check("rs_lat_v", out_valid, 1);
      check("rs_lat_a", out_addr, 30'h11);

      for (int c = 0; c < 500; c++) begin
         drive($urandom_range(0, 3) != 0, 30'($urandom), rand_insn());
         out_ready = $urandom_range(0, 2) != 0;
         flush = $urandom_range(0, 19) == 0;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
